inst_fetch_unit: RTL and testbench

Instruction-fetch initiator for the five-stage pipeline. It drives the instruction memory address and chip-enable, and holds the program counter. It handles stall, branch/jump redirect, and interrupt/exception vectoring. It registers the fetched word and its PC into the IF/ID pipeline register for decode.

---
 rtl/inst_fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch unit for the five-stage pipeline.
// Holds the program counter, drives the instruction memory interface and
// fills the IF/ID register. Exceptions, interrupts and branch/jump
// redirects all override a load-use stall. Every output comes straight
// from a flop.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0004,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0008,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  input  logic [31:0] rom_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        irq_i,
  input  logic        irq_en_i,
  input  logic        exc_i,
  input  logic [31:0] exc_pc_i,
  output logic        irq_ack_o,
  output logic [31:0] epc_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Instruction addresses are word aligned, so the two low bits are always
  // cleared. This also covers a misaligned jump target or vector.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        rom_ce_q, rom_ce_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic        irq_ack_q, irq_ack_d;
  logic [31:0] epc_q, epc_d;
  logic        irq_take_s;

  // An interrupt is refused in the cycle right after an acceptance. This
  // keeps the acknowledge to a single-cycle pulse even if irq_i is still
  // held high.
  assign irq_take_s = irq_i & irq_en_i & ~irq_ack_q;

  // Next-state logic: sequencing, priority of fetch events and IF/ID update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rom_ce_d   = rom_ce_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    irq_ack_d  = 1'b0;
    epc_d      = epc_q;
    case (state_q)
      S_IDLE: begin
        // The first cycle after reset only enables the memory. Nothing is
        // captured and IF/ID keeps its bubble.
        state_d  = S_RUN;
        rom_ce_d = 1'b1;
      end
      S_RUN: begin
        state_d  = S_RUN;
        rom_ce_d = 1'b1;
        if (exc_i) begin
          pc_d       = word_align(EXC_VECTOR);
          epc_d      = exc_pc_i + 32'd4;
          if_pc_d    = pc_q;
          if_inst_d  = NOP_WORD;
          if_valid_d = 1'b0;
        end else if (irq_take_s) begin
          // The fetch being squashed now is where the handler returns to.
          pc_d       = word_align(IRQ_VECTOR);
          epc_d      = pc_q;
          irq_ack_d  = 1'b1;
          if_pc_d    = pc_q;
          if_inst_d  = NOP_WORD;
          if_valid_d = 1'b0;
        end else if (redirect_i) begin
          // There is no delay slot: the word fetched this cycle is dropped.
          pc_d       = word_align(redirect_pc_i);
          if_pc_d    = pc_q;
          if_inst_d  = NOP_WORD;
          if_valid_d = 1'b0;
        end else if (stall_i) begin
          pc_d       = pc_q;
          if_pc_d    = if_pc_q;
          if_inst_d  = if_inst_q;
          if_valid_d = if_valid_q;
        end else begin
          pc_d       = pc_q + 32'd4;
          if_pc_d    = pc_q;
          if_inst_d  = rom_data_i;
          if_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        rom_ce_d   = 1'b0;
        pc_d       = word_align(RESET_VECTOR);
        if_pc_d    = 32'h0000_0000;
        if_inst_d  = NOP_WORD;
        if_valid_d = 1'b0;
        epc_d      = 32'h0000_0000;
      end
    endcase
  end

  // State, PC and IF/ID registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= word_align(RESET_VECTOR);
      rom_ce_q   <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_inst_q  <= NOP_WORD;
      if_valid_q <= 1'b0;
      irq_ack_q  <= 1'b0;
      epc_q      <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rom_ce_q   <= rom_ce_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      irq_ack_q  <= irq_ack_d;
      epc_q      <= epc_d;
    end
  end

  assign rom_addr_o = pc_q;
  assign rom_ce_o   = rom_ce_q;
  assign if_pc_o    = if_pc_q;
  assign if_inst_o  = if_inst_q;
  assign if_valid_o = if_valid_q;
  assign irq_ack_o  = irq_ack_q;
  assign epc_o      = epc_q;

endmodule

// Checker for the fetch unit's interface invariants. It is kept apart from
// the datapath and is bound to a design instance from outside.
module inst_fetch_unit_chk (
  input logic        clk,
  input logic        rst_n,
  input logic [31:0] rom_addr_o,
  input logic        rom_ce_o,
  input logic        irq_ack_o,
  input logic        if_valid_o
);

  // The fetch address is always word aligned.
  a_pc_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    rom_addr_o[1:0] == 2'b00)
    else $error("fetch address misaligned: %h", rom_addr_o);

  // The acknowledge is never high in two consecutive cycles.
  a_ack_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    irq_ack_o |=> !irq_ack_o)
    else $error("irq_ack_o held longer than one cycle");

  // IF/ID never holds a real instruction while memory is disabled.
  a_idle_bubble: assert property (@(posedge clk) disable iff (!rst_n)
    !rom_ce_o |-> !if_valid_o)
    else $error("valid IF/ID entry while memory disabled");

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Table-driven bench for inst_fetch_unit. Each record holds one cycle of
// stimulus and the register state expected after the following clock edge.
// Expected values go into a scoreboard queue and are popped and checked
// after the edge.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] rom_data_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        irq_i;
  logic        irq_en_i;
  logic        exc_i;
  logic [31:0] exc_pc_i;
  logic        irq_ack_o;
  logic [31:0] epc_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  typedef struct packed {
    logic [31:0] pc;
    logic        ce;
    logic [31:0] if_pc;
    logic [31:0] inst;
    logic        valid;
    logic        ack;
    logic [31:0] epc;
  } out_t;

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        irq;
    logic        irq_en;
    logic        exc;
    logic [31:0] exc_pc;
    out_t        exp;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  out_t sb_q[$];
  vec_t tbl[27];

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .rom_addr_o(rom_addr_o), .rom_ce_o(rom_ce_o),
    .rom_data_i(rom_data_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .irq_i(irq_i), .irq_en_i(irq_en_i),
    .exc_i(exc_i), .exc_pc_i(exc_pc_i), .irq_ack_o(irq_ack_o), .epc_o(epc_o),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_valid_o(if_valid_o)
  );

  inst_fetch_unit_chk chk (
    .clk(clk), .rst_n(rst_n), .rom_addr_o(rom_addr_o), .rom_ce_o(rom_ce_o),
    .irq_ack_o(irq_ack_o), .if_valid_o(if_valid_o)
  );

  // Instruction memory contents: two fixed words, all other addresses hold
  // their own address XOR a marker.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0800_0003;
      32'h0000_000C: return 32'h3409_1111;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign rom_data_i = rom_ce_o ? mem_word(rom_addr_o) : 32'h0000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic iq, input logic ie, input logic ex,
                              input logic [31:0] epin, input logic [31:0] pc,
                              input logic ce, input logic [31:0] ifpc,
                              input logic [31:0] inst, input logic v,
                              input logic ack, input logic [31:0] epc);
    vec_t r;
    r.stall = st; r.redir = rd; r.rpc = rpc; r.irq = iq; r.irq_en = ie;
    r.exc = ex; r.exc_pc = epin;
    r.exp.pc = pc; r.exp.ce = ce; r.exp.if_pc = ifpc; r.exp.inst = inst;
    r.exp.valid = v; r.exp.ack = ack; r.exp.epc = epc;
    return r;
  endfunction

  task automatic check(input out_t e, input int idx);
    n_vec++;
    if (rom_addr_o !== e.pc) begin n_bad++;
      $display("FAIL v%0d rom_addr_o: got %h want %h", idx, rom_addr_o, e.pc); end
    if (rom_ce_o !== e.ce) begin n_bad++;
      $display("FAIL v%0d rom_ce_o: got %b want %b", idx, rom_ce_o, e.ce); end
    if (if_pc_o !== e.if_pc) begin n_bad++;
      $display("FAIL v%0d if_pc_o: got %h want %h", idx, if_pc_o, e.if_pc); end
    if (if_inst_o !== e.inst) begin n_bad++;
      $display("FAIL v%0d if_inst_o: got %h want %h", idx, if_inst_o, e.inst); end
    if (if_valid_o !== e.valid) begin n_bad++;
      $display("FAIL v%0d if_valid_o: got %b want %b", idx, if_valid_o, e.valid); end
    if (irq_ack_o !== e.ack) begin n_bad++;
      $display("FAIL v%0d irq_ack_o: got %b want %b", idx, irq_ack_o, e.ack); end
    if (epc_o !== e.epc) begin n_bad++;
      $display("FAIL v%0d epc_o: got %h want %h", idx, epc_o, e.epc); end
  endtask

  task automatic drive_idle();
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    irq_i = 1'b0; irq_en_i = 1'b0; exc_i = 1'b0; exc_pc_i = 32'h0;
  endtask

  // Drive one record, queue its expectation, then check after the edge.
  task automatic step(input int idx);
    out_t e;
    stall_i = tbl[idx].stall; redirect_i = tbl[idx].redir;
    redirect_pc_i = tbl[idx].rpc; irq_i = tbl[idx].irq;
    irq_en_i = tbl[idx].irq_en; exc_i = tbl[idx].exc;
    exc_pc_i = tbl[idx].exc_pc;
    sb_q.push_back(tbl[idx].exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL v%0d scoreboard: got empty queue want 1 entry", idx);
    end else begin
      e = sb_q.pop_front();
      check(e, idx);
    end
  endtask

  localparam out_t RST_OUT = '{pc: 32'h0, ce: 1'b0, if_pc: 32'h0, inst: 32'h0,
                               valid: 1'b0, ack: 1'b0, epc: 32'h0};

  initial begin
    //           st rd rpc            iq ie ex exc_pc        | pc             ce if_pc          inst           v  ack epc
    tbl[0]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         1, 32'h0,         32'h0,         0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h4,         1, 32'h0,         32'h0800_0003, 1, 0, 32'h0);
    tbl[2]  = mk(0, 1, 32'hC,         0, 0, 0, 32'h0,         32'hC,         1, 32'h4,         32'h0,         0, 0, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h10,        1, 32'hC,         32'h3409_1111, 1, 0, 32'h0);
    tbl[4]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h14,        1, 32'h10,        32'hA5A5_0010, 1, 0, 32'h0);
    tbl[5]  = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         32'h14,        1, 32'h10,        32'hA5A5_0010, 1, 0, 32'h0);
    tbl[6]  = mk(1, 1, 32'h40,        0, 0, 0, 32'h0,         32'h40,        1, 32'h14,        32'h0,         0, 0, 32'h0);
    tbl[7]  = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         32'h40,        1, 32'h14,        32'h0,         0, 0, 32'h0);
    tbl[8]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h44,        1, 32'h40,        32'hA5A5_0040, 1, 0, 32'h0);
    tbl[9]  = mk(0, 1, 32'h1F,        0, 0, 0, 32'h0,         32'h1C,        1, 32'h44,        32'h0,         0, 0, 32'h0);
    tbl[10] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h20,        1, 32'h1C,        32'hA5A5_001C, 1, 0, 32'h0);
    tbl[11] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,         32'h4,         1, 32'h20,        32'h0,         0, 1, 32'h20);
    tbl[12] = mk(1, 0, 32'h0,         1, 1, 0, 32'h0,         32'h4,         1, 32'h20,        32'h0,         0, 0, 32'h20);
    tbl[13] = mk(0, 0, 32'h0,         1, 0, 0, 32'h0,         32'h8,         1, 32'h4,         32'hA5A5_0004, 1, 0, 32'h20);
    tbl[14] = mk(0, 0, 32'h0,         1, 0, 0, 32'h0,         32'hC,         1, 32'h8,         32'hA5A5_0008, 1, 0, 32'h20);
    tbl[15] = mk(0, 1, 32'h80,        1, 1, 1, 32'h108,       32'h8,         1, 32'hC,         32'h0,         0, 0, 32'h10C);
    tbl[16] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,         32'h4,         1, 32'h8,         32'h0,         0, 1, 32'h8);
    tbl[17] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h8,         1, 32'h4,         32'hA5A5_0004, 1, 0, 32'h8);
    tbl[18] = mk(1, 0, 32'h0,         0, 0, 1, 32'hFFFF_FFFC, 32'h8,         1, 32'h8,         32'h0,         0, 0, 32'h0);
    tbl[19] = mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 32'h8,         32'h0,         0, 0, 32'h0);
    tbl[20] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1, 0, 32'h0);
    tbl[21] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h4,         1, 32'h0,         32'h0800_0003, 1, 0, 32'h0);
    tbl[22] = mk(0, 0, 32'h0,         0, 0, 1, 32'h30,        32'h8,         1, 32'h4,         32'h0,         0, 0, 32'h34);
    tbl[23] = mk(0, 1, 32'h4C,        0, 0, 0, 32'h0,         32'h4C,        1, 32'h8,         32'h0,         0, 0, 32'h34);
    tbl[24] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h50,        1, 32'h4C,        32'hA5A5_004C, 1, 0, 32'h34);
    // After a mid-run reset: events during the idle cycle are ignored.
    tbl[25] = mk(0, 1, 32'h80,        1, 1, 1, 32'h200,       32'h0,         1, 32'h0,         32'h0,         0, 0, 32'h0);
    tbl[26] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h4,         1, 32'h0,         32'h0800_0003, 1, 0, 32'h0);

    // Power-on reset, checked both before and across a clock edge.
    rst_n = 1'b0;
    drive_idle();
    #2;
    check(RST_OUT, 100);
    @(posedge clk);
    #1;
    check(RST_OUT, 101);
    rst_n = 1'b1;

    for (int i = 0; i <= 24; i++) step(i);

    // Assert reset between edges, with an interrupt pending. Outputs clear
    // at once and stay cleared through an edge.
    rst_n = 1'b0;
    irq_i = 1'b1; irq_en_i = 1'b1;
    #1;
    check(RST_OUT, 102);
    @(posedge clk);
    #1;
    check(RST_OUT, 103);
    rst_n = 1'b1;

    for (int i = 25; i <= 26; i++) step(i);

    if (sb_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard drain: got %0d entries want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
